// File: rtl/exc_flush_ctrl.sv
// exc_flush_ctrl: exception/ertn sequencer between WB, the CSR file and IF.
// It accepts one request at a time and issues a single CSR commit pulse. It
// then holds flush_all for FLUSH_CYCLES cycles and offers IF a redirect PC
// over a valid/ready handshake.
// Optional feature: define EXC_CTRL_INT_EN to add the int_pending/wb_valid
// ports and accept interrupts with top priority.
module exc_flush_ctrl #(
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [5:0]  ECODE_INT    = 6'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_ex,
  input  logic        wb_ertn,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_csr_pc,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        csr_ex_commit,
  output logic        csr_ertn_commit,
  output logic [5:0]  csr_ex_ecode,
  output logic [8:0]  csr_ex_esubcode,
  output logic [31:0] csr_ex_pc,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
`ifdef EXC_CTRL_INT_EN
  ,
  input  logic        int_pending,
  input  logic        wb_valid
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  localparam logic [3:0] LP_FLUSH_CNT = 4'(FLUSH_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ex_commit;
  logic        r_ertn_commit;
  logic [5:0]  r_ecode;
  logic [8:0]  r_esubcode;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic        r_flush;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;
  logic        r_busy;

  // An interrupt needs a valid WB instruction to provide a precise PC.
  logic w_int_take;
`ifdef EXC_CTRL_INT_EN
  assign w_int_take = int_pending & wb_valid;
`else
  assign w_int_take = 1'b0;
`endif

  // An interrupt behaves as an exception; an exception beats a simultaneous ertn.
  logic        w_ex_take;
  logic        w_accept;
  logic [5:0]  w_acc_ecode;
  logic [8:0]  w_acc_esubcode;
  logic [31:0] w_acc_target;

  assign w_ex_take      = w_int_take | wb_ex;
  assign w_accept       = w_ex_take | wb_ertn;
  assign w_acc_ecode    = w_int_take ? ECODE_INT : wb_ecode;
  assign w_acc_esubcode = w_int_take ? 9'd0 : wb_esubcode;
  assign w_acc_target   = w_ex_take ? csr_eentry : csr_era;

  // Sequencer FSM; every output is a register so nothing glitches toward CSR/IF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= 4'd0;
      r_ex_commit      <= 1'b0;
      r_ertn_commit    <= 1'b0;
      r_ecode          <= 6'd0;
      r_esubcode       <= 9'd0;
      r_pc             <= 32'd0;
      r_target         <= 32'd0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_busy           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state       <= S_FLUSH;
            r_cnt         <= LP_FLUSH_CNT;
            r_ex_commit   <= w_ex_take;
            r_ertn_commit <= ~w_ex_take;
            r_ecode       <= w_acc_ecode;
            r_esubcode    <= w_acc_esubcode;
            r_pc          <= wb_csr_pc;
            r_target      <= w_acc_target;
            r_flush       <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        S_FLUSH: begin
          // The commit pulse lasts only for the first flush cycle.
          r_ex_commit   <= 1'b0;
          r_ertn_commit <= 1'b0;
          r_cnt         <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state          <= S_REDIR;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= r_target;
          end
        end
        S_REDIR: begin
          // Hold valid and pc stable until IF takes them, then clear everything.
          if (redirect_ready) begin
            r_state          <= S_IDLE;
            r_cnt            <= 4'd0;
            r_ecode          <= 6'd0;
            r_esubcode       <= 9'd0;
            r_pc             <= 32'd0;
            r_target         <= 32'd0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_busy           <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign csr_ex_commit   = r_ex_commit;
  assign csr_ertn_commit = r_ertn_commit;
  assign csr_ex_ecode    = r_ecode;
  assign csr_ex_esubcode = r_esubcode;
  assign csr_ex_pc       = r_pc;
  assign flush_all       = r_flush;
  assign redirect_valid  = r_redirect_valid;
  assign redirect_pc     = r_redirect_pc;
  assign busy            = r_busy;

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// tb_exc_flush_ctrl: table-driven bench for exc_flush_ctrl. u1 uses
// FLUSH_CYCLES=1 and runs the vector table. u3 uses FLUSH_CYCLES=3 and runs
// the hand-written flush-length and mid-sequence reset sequences.
module tb_exc_flush_ctrl;

  localparam logic [31:0] EENTRY = 32'h1C00_8000;
  localparam logic [31:0] ERA    = 32'h1C00_0104;
  localparam logic [8:0]  ESUB   = 9'h0A3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_ex = 1'b0;
  logic        wb_ertn = 1'b0;
  logic [5:0]  wb_ecode = 6'd0;
  logic [8:0]  wb_esubcode = ESUB;
  logic [31:0] wb_csr_pc = 32'd0;
  logic [31:0] csr_eentry = EENTRY;
  logic [31:0] csr_era = ERA;
  logic        redirect_ready = 1'b0;
`ifdef EXC_CTRL_INT_EN
  logic        int_pending = 1'b0;
  logic        wb_valid = 1'b0;
`endif

  logic        o1_exc, o1_ertnc, o1_flush, o1_rv, o1_busy;
  logic [5:0]  o1_ecode;
  logic [8:0]  o1_esub;
  logic [31:0] o1_pc, o1_rpc;
  logic        o3_exc, o3_ertnc, o3_flush, o3_rv, o3_busy;
  logic [5:0]  o3_ecode;
  logic [8:0]  o3_esub;
  logic [31:0] o3_pc, o3_rpc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exc_flush_ctrl #(.FLUSH_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .wb_ex(wb_ex), .wb_ertn(wb_ertn),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_csr_pc(wb_csr_pc),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .csr_ex_commit(o1_exc), .csr_ertn_commit(o1_ertnc),
    .csr_ex_ecode(o1_ecode), .csr_ex_esubcode(o1_esub), .csr_ex_pc(o1_pc),
    .flush_all(o1_flush), .redirect_valid(o1_rv), .redirect_pc(o1_rpc),
    .redirect_ready(redirect_ready), .busy(o1_busy)
`ifdef EXC_CTRL_INT_EN
    , .int_pending(int_pending), .wb_valid(wb_valid)
`endif
  );

  exc_flush_ctrl #(.FLUSH_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .wb_ex(wb_ex), .wb_ertn(wb_ertn),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_csr_pc(wb_csr_pc),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .csr_ex_commit(o3_exc), .csr_ertn_commit(o3_ertnc),
    .csr_ex_ecode(o3_ecode), .csr_ex_esubcode(o3_esub), .csr_ex_pc(o3_pc),
    .flush_all(o3_flush), .redirect_valid(o3_rv), .redirect_pc(o3_rpc),
    .redirect_ready(redirect_ready), .busy(o3_busy)
`ifdef EXC_CTRL_INT_EN
    , .int_pending(int_pending), .wb_valid(wb_valid)
`endif
  );

  // ctrl = {ex_commit, ertn_commit, flush_all, redirect_valid, busy}
  typedef struct {
    logic        ex;
    logic        ertn;
    logic [5:0]  ec;
    logic [31:0] pc;
    logic        rdy;
    logic [4:0]  e_ctrl;
    logic [31:0] e_rpc;
    logic [5:0]  e_ecode;
    logic [8:0]  e_esub;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic ex, input logic ertn, input logic [5:0] ec,
                         input logic [31:0] pc, input logic rdy, input logic [4:0] e_ctrl,
                         input logic [31:0] e_rpc, input logic [5:0] e_ecode,
                         input logic [8:0] e_esub, input logic [31:0] e_pc);
    vec_t v;
    v.ex = ex; v.ertn = ertn; v.ec = ec; v.pc = pc; v.rdy = rdy;
    v.e_ctrl = e_ctrl; v.e_rpc = e_rpc; v.e_ecode = e_ecode;
    v.e_esub = e_esub; v.e_pc = e_pc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ex, input logic ertn, input logic [5:0] ec,
                       input logic [31:0] pc, input logic rdy);
    @(negedge clk);
    wb_ex = ex; wb_ertn = ertn; wb_ecode = ec; wb_csr_pc = pc; redirect_ready = rdy;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ctrl1();
    return {o1_exc, o1_ertnc, o1_flush, o1_rv, o1_busy};
  endfunction
  function automatic logic [4:0] ctrl3();
    return {o3_exc, o3_ertnc, o3_flush, o3_rv, o3_busy};
  endfunction
  function automatic logic [78:0] data1();
    return {o1_rpc, o1_ecode, o1_esub, o1_pc};
  endfunction
  function automatic logic [78:0] data3();
    return {o3_rpc, o3_ecode, o3_esub, o3_pc};
  endfunction

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    wb_ex = 1'b0; wb_ertn = 1'b0; redirect_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // ---- vector table for u1 (FLUSH_CYCLES=1) ----
    // Single exception, ready high: commit at N+1, redirect at N+2, idle at N+3.
    add_row(1, 0, 6'h0B, 32'h1C00_0100, 1, 5'b10101, 32'd0,  6'h0B, ESUB, 32'h1C00_0100);
    add_row(0, 0, 6'h00, 32'd0,         1, 5'b00111, EENTRY, 6'h0B, ESUB, 32'h1C00_0100);
    add_row(0, 0, 6'h00, 32'd0,         1, 5'b00000, 32'd0,  6'h00, 9'd0, 32'd0);
    add_row(0, 0, 6'h00, 32'd0,         1, 5'b00000, 32'd0,  6'h00, 9'd0, 32'd0);
    // ertn with IF stalling: one ertn pulse, redirect_pc held until ready.
    add_row(0, 1, 6'h00, 32'h1C00_0300, 0, 5'b01101, 32'd0,  6'h00, ESUB, 32'h1C00_0300);
    add_row(0, 0, 6'h00, 32'd0,         0, 5'b00111, ERA,    6'h00, ESUB, 32'h1C00_0300);
    add_row(0, 0, 6'h00, 32'd0,         0, 5'b00111, ERA,    6'h00, ESUB, 32'h1C00_0300);
    add_row(0, 0, 6'h00, 32'd0,         0, 5'b00111, ERA,    6'h00, ESUB, 32'h1C00_0300);
    add_row(0, 0, 6'h00, 32'd0,         0, 5'b00111, ERA,    6'h00, ESUB, 32'h1C00_0300);
    add_row(0, 0, 6'h00, 32'd0,         1, 5'b00000, 32'd0,  6'h00, 9'd0, 32'd0);
    // ex and ertn together: exception wins, target is eentry.
    add_row(1, 1, 6'h0C, 32'h1C00_0400, 1, 5'b10101, 32'd0,  6'h0C, ESUB, 32'h1C00_0400);
    add_row(0, 0, 6'h00, 32'd0,         1, 5'b00111, EENTRY, 6'h0C, ESUB, 32'h1C00_0400);
    add_row(0, 0, 6'h00, 32'd0,         1, 5'b00000, 32'd0,  6'h00, 9'd0, 32'd0);
    // Requests while busy are ignored; latched ecode stays 0x0B.
    add_row(1, 0, 6'h0B, 32'h1C00_0100, 1, 5'b10101, 32'd0,  6'h0B, ESUB, 32'h1C00_0100);
    add_row(1, 0, 6'h08, 32'h1C00_0500, 0, 5'b00111, EENTRY, 6'h0B, ESUB, 32'h1C00_0100);
    add_row(1, 0, 6'h08, 32'h1C00_0500, 0, 5'b00111, EENTRY, 6'h0B, ESUB, 32'h1C00_0100);
    add_row(0, 1, 6'h08, 32'h1C00_0500, 0, 5'b00111, EENTRY, 6'h0B, ESUB, 32'h1C00_0100);
    add_row(1, 0, 6'h08, 32'h1C00_0500, 1, 5'b00000, 32'd0,  6'h00, 9'd0, 32'd0);
    add_row(0, 0, 6'h00, 32'd0,         0, 5'b00000, 32'd0,  6'h00, 9'd0, 32'd0);

    // ---- reset state ----
    repeat (2) @(negedge clk);
    #1;
    chk("reset_u1_ctrl", 128'(ctrl1()), 128'd0);
    chk("reset_u1_data", 128'(data1()), 128'd0);
    chk("reset_u3_ctrl", 128'(ctrl3()), 128'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ex, tbl[i].ertn, tbl[i].ec, tbl[i].pc, tbl[i].rdy);
      step();
      $display("row %0d: ex=%0b ertn=%0b rdy=%0b ctrl=%05b rpc=%08h ecode=%02h pc=%08h",
               i, tbl[i].ex, tbl[i].ertn, tbl[i].rdy, ctrl1(), o1_rpc, o1_ecode, o1_pc);
      chk($sformatf("row%0d_ctrl", i), 128'(ctrl1()), 128'(tbl[i].e_ctrl));
      chk($sformatf("row%0d_data", i), 128'(data1()),
          128'({tbl[i].e_rpc, tbl[i].e_ecode, tbl[i].e_esub, tbl[i].e_pc}));
    end

    // ---- u3: three flush cycles before redirect, early ready ignored ----
    do_reset();
    drive(1, 0, 6'h0B, 32'h1C00_0100, 1);
    step();
    chk("fc3_c1", 128'(ctrl3()), 128'(5'b10101));
    drive(0, 0, 6'h00, 32'd0, 1);
    step();
    chk("fc3_c2", 128'(ctrl3()), 128'(5'b00101));
    step();
    chk("fc3_c3", 128'(ctrl3()), 128'(5'b00101));
    step();
    chk("fc3_redir", 128'(ctrl3()), 128'(5'b00111));
    chk("fc3_rpc", 128'(o3_rpc), 128'(EENTRY));
    step();
    chk("fc3_idle", 128'(ctrl3()), 128'd0);
    $display("fc3 sequence: flush then redirect done, ctrl=%05b", ctrl3());

    // ---- u3: reset asserted in the 2nd flush cycle ----
    drive(1, 0, 6'h0B, 32'h1C00_0100, 0);
    step();
    chk("rst_seq_c1", 128'(ctrl3()), 128'(5'b10101));
    drive(0, 0, 6'h00, 32'd0, 0);
    step();
    chk("rst_seq_c2", 128'(ctrl3()), 128'(5'b00101));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_ctrl", 128'(ctrl3()), 128'd0);
    chk("rst_async_data", 128'(data3()), 128'd0);
    $display("mid-sequence reset: ctrl=%05b", ctrl3());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("post_rst%0d", k), 128'(ctrl3()), 128'd0);
    end

`ifdef EXC_CTRL_INT_EN
    // ---- interrupt beats wb_ex; int without wb_valid is not taken ----
    do_reset();
    @(negedge clk);
    int_pending = 1'b1; wb_valid = 1'b1;
    wb_ex = 1'b1; wb_ertn = 1'b0; wb_ecode = 6'h0B; wb_csr_pc = 32'h1C00_0200; redirect_ready = 1'b1;
    step();
    chk("int_ctrl", 128'(ctrl1()), 128'(5'b10101));
    chk("int_data", 128'({o1_ecode, o1_esub, o1_pc}), 128'({6'h00, 9'd0, 32'h1C00_0200}));
    @(negedge clk);
    int_pending = 1'b0; wb_valid = 1'b0; wb_ex = 1'b0;
    step();
    chk("int_rpc", 128'(o1_rpc), 128'(EENTRY));
    step();
    @(negedge clk);
    int_pending = 1'b1; wb_valid = 1'b0;
    step();
    chk("int_novalid", 128'(ctrl1()), 128'd0);
    $display("interrupt sequence done, ctrl=%05b", ctrl1());
    @(negedge clk);
    int_pending = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exc_flush_ctrl.md
Name: exc_flush_ctrl

Overview:
- Pipeline exception/return sequencer, placed between the WB stage, the CSR file and IF.
- Samples exception and ertn requests from WB and drives a one-cycle commit pulse to the CSR file.
- Holds a global flush on all stages, then hands IF a redirect PC using a valid/ready handshake.
- Guarantees exactly one CSR commit and one redirect per event, and ignores further requests while busy.

Parameters:
- FLUSH_CYCLES, 1, cycles `flush_all` is held before `redirect_valid` rises; legal range 1..15.
- ECODE_INT, 6'h00, ecode reported for an accepted interrupt; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wb_ex  in  1  WB exception request, already qualified with WB valid
- wb_ertn  in  1  WB ertn request, already qualified with WB valid
- wb_ecode  in  6  exception code
- wb_esubcode  in  9  exception subcode
- wb_csr_pc  in  32  PC of the WB instruction
- csr_eentry  in  32  exception entry address
- csr_era  in  32  exception return address
- csr_ex_commit  out  1  one-cycle pulse: CSR file updates ESTAT/ERA/PRMD
- csr_ertn_commit  out  1  one-cycle pulse: CSR file restores PRMD
- csr_ex_ecode  out  6  latched ecode, valid during `csr_ex_commit`
- csr_ex_esubcode  out  9  latched subcode, valid during `csr_ex_commit`
- csr_ex_pc  out  32  latched PC, valid during `csr_ex_commit`
- flush_all  out  1  flush IF/ID/EXE/MEM/WB
- redirect_valid  out  1  redirect offered to IF
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  IF accepts the redirect
- busy  out  1  state is not IDLE
- int_pending  in  1  CSR interrupt request; present only with `EXC_CTRL_INT_EN`
- wb_valid  in  1  WB holds a valid instruction; present only with `EXC_CTRL_INT_EN`

Behaviour:
- Reset (asynchronous): state=IDLE, counter=0. All outputs 0, including every latched field.
- States are IDLE, FLUSH and REDIR.
- IDLE, request accepted:
  - Priority is (int) > `wb_ex` > `wb_ertn`.
  - On acceptance, latch ecode, esubcode and PC, and latch target = `csr_eentry` (exception) or `csr_era` (ertn), both sampled in the accept cycle.
  - Load counter with FLUSH_CYCLES and go to FLUSH.
- IDLE, no request: all outputs 0.
- FLUSH:
  - `flush_all`=1 and `busy`=1.
  - In the first FLUSH cycle only, `csr_ex_commit` or `csr_ertn_commit` is 1 (exactly one pulse).
  - The counter decrements each cycle; the transition to REDIR happens on the cycle the counter reaches 1.
- REDIR:
  - `flush_all`=1, `redirect_valid`=1, `redirect_pc`=latched target.
  - `redirect_pc` and `redirect_valid` stay stable until `redirect_ready`.
  - On `redirect_valid` & `redirect_ready`, go to IDLE. `flush_all` and `redirect_valid` are 0 the next cycle.
- Latency: a request in cycle N produces commit and `flush_all` at N+1. `redirect_valid` first rises at N+1+FLUSH_CYCLES.
- Requests (`wb_ex`, `wb_ertn`, `int_pending`) while `busy` are ignored; no latching and no pulse.
- `wb_ex` and `wb_ertn` in the same cycle: the exception wins and no ertn commit is issued.
- `redirect_ready` held high early (in IDLE or FLUSH) has no effect.
- `reset` asserted mid-sequence: immediate return to IDLE with all outputs 0. No commit pulse is issued after reset release.
- The commit pulse and the first `flush_all` cycle coincide. The CSR file writes on that edge, so the CSR read path in WB is squashed by `flush_all`.

Optional Feature:
- Macro `EXC_CTRL_INT_EN`.
- Defined:
  - `int_pending` and `wb_valid` ports exist.
  - In IDLE, `int_pending` & `wb_valid` is accepted with top priority: ecode=ECODE_INT, esubcode=0, pc=`wb_csr_pc`, target=`csr_eentry`, and an ex commit is issued.
  - `int_pending` without `wb_valid` is not taken, since there is no precise PC.
- Undefined: the ports are absent and interrupts are never accepted. All other behaviour is identical.

Test Plan:
- FLUSH_CYCLES=1; `wb_ex`=1 with ecode=0x0B, pc=0x1C000100, eentry=0x1C008000, `redirect_ready`=1 →
  - cycle N+1: `csr_ex_commit`=1 with ecode 0x0B and pc 0x1C000100, `flush_all`=1;
  - cycle N+2: `redirect_valid`=1 with `redirect_pc`=0x1C008000, IDLE at N+3.
- `wb_ertn`=1 with era=0x1C000104 and `redirect_ready` low for 3 cycles → `csr_ertn_commit` pulses once; `redirect_pc`=0x1C000104 is held stable through the stall; `flush_all` stays high until the handshake.
- `wb_ex` and `wb_ertn` asserted together → only `csr_ex_commit`; target = eentry.
- New `wb_ex` with ecode 0x08 while in REDIR → ignored; latched ecode stays 0x0B; no second commit.
- FLUSH_CYCLES=3 → `flush_all` is high for 3 cycles before `redirect_valid`; reset asserted in the 2nd cycle → all outputs 0 immediately; no commit pulse after release.
- With `EXC_CTRL_INT_EN`: `int_pending`, `wb_valid` and `wb_ex` (ecode 0x0B) all 1 with pc 0x1C000200 → `csr_ex_commit` with ecode 0x00, pc 0x1C000200; `int_pending`=1 with `wb_valid`=0 → no action.
